// File: rtl/alu_pkg.sv
// Shared types for the ALU command path: op codes, queued command entry, sequencer state.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    MUL  = 3'd2,
    AND  = 3'd3,
    OR   = 3'd4,
    XOR  = 3'd5,
    NOT1 = 3'd6,
    NOT2 = 3'd7
  } alu_op_t;

  // One queued command; use_acc swaps operand a for the accumulator at issue time.
  typedef struct packed {
    alu_op_t                op;
    logic [ALU_WIDTH-1:0]   a;
    logic [ALU_WIDTH-1:0]   b;
    logic                   use_acc;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of DEPTH entries of any packed type, head visible on pop_data.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push is ignored while full, pop is ignored while empty.
module alu_cmd_fifo #(
  parameter int DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally (DEPTH is a power of two); count separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues one at a time to the external ALU, returns result+flag, keeps an accumulator.
// Latency: 3 cycles from command acceptance to res_valid on an empty pipe; one result per 2 cycles sustained.
// Backpressure: cmd_ready = !full (low during reset); a result is held stable until res_ready.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,  // must equal ALU_WIDTH
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  input  logic             clear_acc,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [2:0]       alu_sel,
  output logic             alu_e1,
  output logic             alu_e2_bar,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [2:0]       res_op,
  output logic             res_flag,
  output logic [WIDTH-1:0] acc
);

  seq_state_t         state;
  seq_state_t         state_nxt;
  alu_cmd_t           cmd_entry;
  alu_cmd_t           head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               cmd_push;
  logic               ready_en;
  logic               flag_nxt;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // ready_en keeps cmd_ready low until the first edge after reset is released.
  assign cmd_ready = ready_en && !fifo_full;
  assign cmd_push  = cmd_valid && cmd_ready;
  assign res_valid = (state == ST_RESP);
  assign cmd_entry = '{op: alu_op_t'(cmd_op), a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};

  alu_cmd_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (alu_cmd_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_push),
    .push_data (cmd_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register plus the startup gate for cmd_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
    end
  end

  // Next state and pop request: issue whenever work is queued and no result is pending.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        if (res_ready) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = ST_EXEC;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ALU pin registers: operands load on pop; enables select the active encoding only for the EXEC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_sel    <= '0;
      alu_e1     <= 1'b1;
      alu_e2_bar <= 1'b0;
    end else begin
      if (fifo_pop) begin
        alu_in1 <= head.use_acc ? acc : head.a;
        alu_in2 <= head.b;
        alu_sel <= head.op;
      end
      alu_e1     <= (state_nxt != ST_EXEC);
      alu_e2_bar <= (state_nxt == ST_EXEC);
    end
  end

  // Flag derived from the issued operands, not from the ALU output.
  always_comb begin
    sum      = {1'b0, alu_in1} + {1'b0, alu_in2};
    prod     = {{WIDTH{1'b0}}, alu_in1} * {{WIDTH{1'b0}}, alu_in2};
    flag_nxt = 1'b0;
    case (alu_sel)
      ADD:     flag_nxt = (sum >> WIDTH) != '0;
      SUB:     flag_nxt = (alu_in1 < alu_in2);
      MUL:     flag_nxt = (prod >> WIDTH) != '0;
      default: flag_nxt = 1'b0;
    endcase
  end

  // Result capture at the end of EXEC; clear_acc wins over the accumulator update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data <= '0;
      res_op   <= '0;
      res_flag <= 1'b0;
      acc      <= '0;
    end else begin
      if (state == ST_EXEC) begin
        res_data <= alu_out;
        res_op   <= alu_sel;
        res_flag <= flag_nxt;
      end
      if (clear_acc) begin
        acc <= '0;
      end else if (state == ST_EXEC) begin
        acc <= alu_out;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural ALU and an in-order result reference.
// Latency: n/a.
// Backpressure: res_ready driven directly by the stimulus.
module tb_alu_cmd_sequencer;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] data;
    logic       flag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic       cmd_use_acc = 1'b0;
  logic       clear_acc = 1'b0;
  logic [3:0] alu_in1, alu_in2;
  logic [2:0] alu_sel;
  logic       alu_e1, alu_e2_bar;
  logic [3:0] alu_out;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic [2:0] res_op;
  logic       res_flag;
  logic [3:0] acc;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ref_acc  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  alu_cmd_sequencer #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .clear_acc(clear_acc), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel),
    .alu_e1(alu_e1), .alu_e2_bar(alu_e2_bar), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_op(res_op), .res_flag(res_flag), .acc(acc)
  );

  always #5 clk = ~clk;

  // External 4-bit ALU: output forced to zero unless E1=0 and E2_bar=1.
  always_comb begin
    alu_out = '0;
    if (!alu_e1 && alu_e2_bar) begin
      case (alu_sel)
        3'd0: alu_out = alu_in1 + alu_in2;
        3'd1: alu_out = alu_in1 - alu_in2;
        3'd2: alu_out = alu_in1 * alu_in2;
        3'd3: alu_out = alu_in1 & alu_in2;
        3'd4: alu_out = alu_in1 | alu_in2;
        3'd5: alu_out = alu_in1 ^ alu_in2;
        3'd6: alu_out = (alu_in1 == 4'd0) ? 4'd1 : 4'd0;
        default: alu_out = (alu_in2 == 4'd0) ? 4'd1 : 4'd0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference result of one command from arithmetic on plain integers.
  function automatic exp_t ref_op(input int op, input int x, input int y);
    exp_t e;
    int   r;
    bit   f;
    f = 1'b0;
    case (op)
      0: begin r = x + y; f = (r > 15); end
      1: begin r = x - y; f = (x < y);  end
      2: begin r = x * y; f = (r > 15); end
      3: r = x & y;
      4: r = x | y;
      5: r = x ^ y;
      6: r = (x == 0) ? 1 : 0;
      default: r = (y == 0) ? 1 : 0;
    endcase
    e.op   = 3'(op);
    e.data = 4'(((r % 16) + 16) % 16);
    e.flag = f;
    return e;
  endfunction

  task automatic model_push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic ua);
    exp_t e;
    e = ref_op(int'(op), ua ? ref_acc : int'(a), int'(b));
    ref_acc = int'(e.data);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return one cycle after it was accepted.
  task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic ua);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    if (!cmd_ready) check("push_timeout", 0, 1);
    else model_push(op, a, b, ua);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic run_one(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] exp_d, input logic exp_f, input string tag);
    int n;
    push(op, a, b, 1'b0);
    n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_data"}, res_data, exp_d);
    check({tag, "_flag"}, res_flag, exp_f);
    wait_drain();
  endtask

  // Consumer-side scoreboard: every accepted result must match the next reference entry.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_data", res_data, mon_e.data);
        check("sb_op", res_op, mon_e.op);
        check("sb_flag", res_flag, mon_e.flag);
      end
    end
  end

  initial begin
    int vcyc[$];
    int sent;
    int acc_flag;

    // Reset values.
    tick(); tick();
    check("rst_acc", acc, 0);        check("rst_in1", alu_in1, 0);
    check("rst_in2", alu_in2, 0);    check("rst_sel", alu_sel, 0);
    check("rst_e1", alu_e1, 1);      check("rst_e2b", alu_e2_bar, 0);
    check("rst_valid", res_valid, 0); check("rst_data", res_data, 0);
    check("rst_ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    check("ready_after_release", cmd_ready, 0);
    tick();
    check("ready_first_edge", cmd_ready, 1);

    // ADD 9+8: latency and enable encoding.
    res_ready = 1'b1;
    push(3'd0, 4'd9, 4'd8, 1'b0);
    check("lat_c1_valid", res_valid, 0); check("lat_c1_e1", alu_e1, 1); check("lat_c1_e2b", alu_e2_bar, 0);
    tick();
    check("lat_c2_valid", res_valid, 0); check("lat_c2_e1", alu_e1, 0); check("lat_c2_e2b", alu_e2_bar, 1);
    tick();
    check("lat_c3_valid", res_valid, 1); check("lat_c3_data", res_data, 1);
    check("lat_c3_flag", res_flag, 1);   check("lat_c3_acc", acc, 1);
    check("lat_c3_e1", alu_e1, 1);       check("lat_c3_e2b", alu_e2_bar, 0);
    wait_drain();

    // Directed ops and flag rules.
    run_one(3'd1, 4'd3, 4'd5, 4'd14, 1'b1, "sub_3_5");
    run_one(3'd2, 4'd5, 4'd3, 4'd15, 1'b0, "mul_5_3");
    run_one(3'd2, 4'd5, 4'd4, 4'd4,  1'b1, "mul_5_4");
    run_one(3'd6, 4'd0, 4'd9, 4'd1,  1'b0, "not1_0");
    run_one(3'd7, 4'd6, 4'd3, 4'd0,  1'b0, "not2_3");

    // Chaining through the accumulator, with clear on the second capture edge.
    push(3'd0, 4'd2, 4'd3, 1'b0);
    push(3'd0, 4'd0, 4'd4, 1'b1);
    acc_flag = 0;
    for (int i = 0; i < 20 && acc_flag < 2; i++) begin
      if (!alu_e1) acc_flag++;
      if (acc_flag < 2) tick();
    end
    check("chain_exec2_seen", acc_flag, 2);
    clear_acc = 1'b1;
    tick();
    clear_acc = 1'b0;
    check("chain_clear_acc", acc, 0);
    check("chain_res_data", res_data, 9);
    ref_acc = 0;
    wait_drain();

    // Backpressure: five commands fill one executing slot plus four queued.
    res_ready = 1'b0;
    push(3'd0, 4'd1, 4'd1, 1'b0);
    push(3'd3, 4'd12, 4'd10, 1'b0);
    push(3'd4, 4'd5, 4'd2, 1'b0);
    push(3'd5, 4'd15, 4'd6, 1'b0);
    push(3'd1, 4'd0, 4'd1, 1'b0);
    tick();
    check("bp_ready_low", cmd_ready, 0);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_data", res_data, exp_q[0].data);
      tick();
    end
    res_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (res_valid) vcyc.push_back(c);
      tick();
    end
    check("bp_drain_count", vcyc.size(), 5);
    for (int i = 1; i < vcyc.size(); i++) check("bp_drain_gap", vcyc[i] - vcyc[i-1], 2);
    wait_drain();

    // Reset during EXEC with two entries still queued.
    res_ready = 1'b0;
    push(3'd0, 4'd3, 4'd4, 1'b0);
    push(3'd0, 4'd5, 4'd6, 1'b0);
    push(3'd0, 4'd7, 4'd1, 1'b0);
    push(3'd0, 4'd2, 4'd2, 1'b0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("mid_rst_in_exec", alu_e1, 0);
    rst = 1'b1;
    #1;
    exp_q.delete();
    ref_acc = 0;
    check("mid_rst_valid", res_valid, 0); check("mid_rst_acc", acc, 0);
    check("mid_rst_in1", alu_in1, 0);     check("mid_rst_in2", alu_in2, 0);
    check("mid_rst_sel", alu_sel, 0);     check("mid_rst_e1", alu_e1, 1);
    check("mid_rst_e2b", alu_e2_bar, 0);  check("mid_rst_data", res_data, 0);
    check("mid_rst_op", res_op, 0);       check("mid_rst_flag", res_flag, 0);
    check("mid_rst_ready", cmd_ready, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", cmd_ready, 1);
    tick(); tick(); tick();
    check("post_rst_no_valid", res_valid, 0);
    res_ready = 1'b1;
    run_one(3'd0, 4'd7, 4'd7, 4'd14, 1'b0, "post_rst_add");

    // Random commands with random consumer stalls.
    sent = 0;
    for (int cyc = 0; cyc < 3000 && (sent < 40 || exp_q.size() != 0); cyc++) begin
      logic accepted;
      res_ready = ($urandom_range(0, 3) != 0);
      if (!cmd_valid && sent < 40 && $urandom_range(0, 1) == 1) begin
        cmd_valid   = 1'b1;
        cmd_op      = 3'($urandom_range(0, 7));
        cmd_a       = 4'($urandom_range(0, 15));
        cmd_b       = 4'($urandom_range(0, 15));
        cmd_use_acc = ($urandom_range(0, 3) == 0);
      end
      accepted = cmd_valid && cmd_ready;
      if (accepted) begin
        model_push(cmd_op, cmd_a, cmd_b, cmd_use_acc);
        sent++;
      end
      tick();
      if (accepted) cmd_valid = 1'b0;
    end
    check("rand_sent", sent, 40);
    check("rand_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command sequencer directly upstream of the 4-bit `ALU`, with a result stage that consumes its output. It buffers operation commands in a small FIFO and issues one command at a time on the ALU's operand, select and enable pins. It captures the combinational ALU result, keeps a running accumulator for chained operations, and returns each result with a carry/borrow/overflow flag over a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 4: operand/result width; must match the ALU.
- `DEPTH`, 4: command FIFO entries, power of two ≥ 2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; equals `!full`.
- `cmd_op`  in  3  ALU select code (`alu_op_t`).
- `cmd_a`, `cmd_b`  in  WIDTH  operands.
- `cmd_use_acc`  in  1  replace `cmd_a` with the accumulator at execute time.
- `clear_acc`  in  1  one-cycle pulse; zero the accumulator.
- `alu_in1`, `alu_in2`  out  WIDTH  to ALU `in1`/`in2`; registered.
- `alu_sel`  out  3  to ALU `sel`; registered.
- `alu_e1`, `alu_e2_bar`  out  1  to ALU `E1`/`E2_bar`; registered.
- `alu_out`  in  WIDTH  from ALU `out`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts.
- `res_data`  out  WIDTH  captured result.
- `res_op`  out  3  op that produced `res_data`.
- `res_flag`  out  1  carry/borrow/overflow.
- `acc`  out  WIDTH  accumulator.

## Operation
- Command handshake: an entry is pushed when `cmd_valid && cmd_ready`. The FIFO stores `{op, a, b, use_acc}`. A push into a full FIFO is impossible by construction, because `cmd_ready` is low. There is no pass-through when full, even with a simultaneous pop.
- FSM states and transitions:
  - IDLE: when the FIFO is non-empty, pop the head, load `alu_in1/alu_in2/alu_sel`, and go to EXEC. `alu_in1` is loaded from `acc` if `use_acc` is set, else from `a`.
  - EXEC: lasts 1 cycle. Drive `alu_e1=0`, `alu_e2_bar=1`. On the closing edge, register `res_data<=alu_out`, `res_op`, and `res_flag`, and update `acc<=alu_out`. Go to RESP.
  - RESP: `res_valid=1`, with data held stable until `res_ready`.
    - On `res_ready` with the FIFO non-empty: pop the next entry and go to EXEC.
    - On `res_ready` with the FIFO empty: go to IDLE.
- Park encoding: outside EXEC, drive `alu_e1=1`, `alu_e2_bar=0`, which forces the ALU output to 0. Operand/select registers keep their last values.
- `res_flag` is computed from the registered operands, independent of `alu_out`:
  - op 0 (ADD): bit WIDTH of the (WIDTH+1)-bit sum.
  - op 1 (SUB): `in1 < in2`.
  - op 2 (MUL): upper WIDTH bits of the 2·WIDTH product are non-zero.
  - ops 3–7: 0.
- Results are modulo 2^WIDTH, as the ALU produces them.
- Chaining: a `use_acc` command sees the result of the immediately preceding command, because `acc` is updated at the EXEC edge, before the next pop.
- `clear_acc` coinciding with the EXEC capture edge: clear wins (`acc<=0`); `res_data` still reports `alu_out`.
- Reset, including mid-operation: FIFO emptied, FSM→IDLE, any in-flight command and pending result discarded. Output values under reset:
  - 0: `acc`, `alu_in1`, `alu_in2`, `alu_sel`, `alu_e2_bar`, `res_valid`, `res_data`, `res_op`, `res_flag`, `cmd_ready`.
  - 1: `alu_e1`.
  - `cmd_ready` rises on the first edge after `rst` deasserts.

## Timing
- Cycle 0: command accepted.
- Cycle 1: IDLE sees non-empty FIFO and pops.
- Cycle 2: EXEC.
- Cycle 3: `res_valid=1`. Latency from acceptance to `res_valid` is 3 cycles with an empty pipe.
- Throughput: one result per 2 cycles when `res_ready` is held high and the FIFO is non-empty.
- `res_*` and `acc` change only at the EXEC edge, or at reset/`clear_acc` for `acc`.
- FIFO pointers wrap modulo `DEPTH`. The full/empty distinction uses a count or an extra pointer bit.

## Structure
- Shared package `alu_pkg`:
  - `ALU_WIDTH=4`.
  - `typedef enum logic [2:0] alu_op_t` with values ADD, SUB, MUL, AND, OR, XOR, NOT1, NOT2 = 0..7.
  - Packed struct `alu_cmd_t` holding `{op, a, b, use_acc}`.
  - FSM state enum.
- One sub-module: `alu_cmd_fifo`, a synchronous FIFO parameterised by `DEPTH` and entry type, with push/pop/full/empty and asynchronous reset.

## Test plan
- Reset, then push op 0 with a=9, b=8: `res_valid` rises 3 cycles after acceptance; `res_data=1`, `res_flag=1`, `acc=1`. `alu_e1/alu_e2_bar` read 0/1 only in the EXEC cycle.
- Op 1 with a=3, b=5 → `res_data=14`, `res_flag=1`. Op 2 with a=5, b=3 → 15, flag 0. Op 2 with a=5, b=4 → 4, flag 1.
- Chain: op 0 with a=2, b=3, then op 0 with `use_acc=1`, b=4 → results 5 then 9. Assert `clear_acc` on the second EXEC edge → `acc=0`, `res_data=9`.
- Hold `res_ready=0` and push 5 commands (`DEPTH=4`): `cmd_ready` drops after 4 accepted with one executing; data stays stable. Release `res_ready`: all results drain in order, one per 2 cycles.
- Assert `rst` during EXEC with 2 entries queued: no `res_valid`, FIFO empty, all outputs at reset values. A new command afterwards completes normally.
- Op 6 with a=0 → `res_data=1`. Op 7 with b=3 → `res_data=0`. `res_flag=0` for both.
